// File: rtl/divider_pkg.sv
// Shared constants and types for the divide unit:
// ALU opcodes, FSM state encoding and iteration count.
package divider_pkg;

    localparam logic [5:0] OP_ADD  = 6'd32;
    localparam logic [5:0] OP_SUB  = 6'd34;
    localparam logic [5:0] OP_AND  = 6'd36;
    localparam logic [5:0] OP_OR   = 6'd37;
    localparam logic [5:0] OP_SLT  = 6'd42;
    localparam logic [5:0] OP_DIVU = 6'd27;

    localparam int ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_divu(input logic [5:0] op);
        return op == OP_DIVU;
    endfunction

endpackage

// File: rtl/divider_sub33.sv
// Combinational wide subtractor; borrow is set when a < b.
module div_sub33 #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    always_comb begin
        {borrow, diff} = {1'b0, a} - {1'b0, b};
    end

endmodule

// File: rtl/divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// Result is {remainder, quotient}.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    input  logic [5:0]         Signal,
    output logic [2*WIDTH-1:0] dataOut,
    output logic               busy,
    output logic               done,
    output logic               divZero
);

    localparam int W = WIDTH;

    state_t           state;
    logic [5:0]       cnt;
    logic [2*W-1:0]   work;
    logic [W-1:0]     divisor;
    logic [W:0]       diff;
    logic             borrow;

    // Upper half after the left shift, with the carried-out bit kept
    div_sub33 #(.W(W + 1)) u_sub (
        .a      (work[2*W-1:W-1]),
        .b      ({1'b0, divisor}),
        .diff   (diff),
        .borrow (borrow)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            work    <= '0;
            divisor <= '0;
            dataOut <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divZero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (is_divu(Signal)) begin
                        divisor <= dataB;
                        cnt     <= '0;
                        work    <= {{W{1'b0}}, dataA};
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (borrow)
                        work <= {work[2*W-2:0], 1'b0};
                    else
                        work <= {diff[W-1:0], work[W-2:0], 1'b1};
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(ITERS - 1))
                        state <= DONE;
                end
                DONE: begin
                    dataOut <= work;
                    divZero <= (divisor == '0);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed bench for the iterative divider.
module tb_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [5:0]  Signal;
    logic [63:0] dataOut;
    logic        busy;
    logic        done;
    logic        divZero;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (done) pulses++;

    divider #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .dataA   (dataA),
        .dataB   (dataB),
        .Signal  (Signal),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done),
        .divZero (divZero)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dataA  = a;
        dataB  = b;
        Signal = 6'd27;
        @(posedge clk);
        #1;
        Signal = 6'd0;
        dataA  = 32'hDEAD_BEEF;
        dataB  = 32'h0000_0001;
    endtask

    // Waits for done; returns edges since the start edge (0 on timeout)
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] q,
                           input logic [31:0] r, input logic z);
        int lat;
        int p0;
        p0 = pulses;
        start(a, b);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(lat);
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check({tag, "_out"}, dataOut, {r, q});
        check({tag, "_dz"}, 64'(divZero), 64'(z));
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_hold"}, dataOut, {r, q});
        check({tag, "_npulse"}, 64'(pulses - p0), 64'd1);
    endtask

    initial begin
        int lat;
        int p0;
        reset  = 1'b0;
        Signal = 6'd0;
        dataA  = 32'd0;
        dataB  = 32'd0;
        #1;
        check("rst_out", dataOut, 64'd0);
        check("rst_flags", {61'd0, busy, done, divZero}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_div("dmax_big", 32'hFFFF_FFFF, 32'h8000_0000,
                32'd1, 32'h7FFF_FFFF, 1'b0);
        run_div("d5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);

        // divZero held until next completion
        repeat (3) @(posedge clk);
        #1;
        check("dz_hold", 64'(divZero), 64'd1);

        run_div("d3_10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0);

        // Non-divide opcode is ignored
        p0 = pulses;
        @(negedge clk);
        dataA  = 32'd50;
        dataB  = 32'd5;
        Signal = 6'd32;
        @(posedge clk);
        #1;
        check("add_busy", 64'(busy), 64'd0);
        Signal = 6'd0;
        repeat (40) @(posedge clk);
        #1;
        check("add_nodone", 64'(pulses - p0), 64'd0);
        check("add_out", dataOut, {32'd3, 32'd0});

        // Second DIVU while busy is dropped
        p0 = pulses;
        start(32'd100, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        dataA  = 32'd9;
        dataB  = 32'd3;
        Signal = 6'd27;
        @(posedge clk);
        #1;
        Signal = 6'd0;
        wait_done(lat);
        check("busy_lat", 64'(lat), 64'd28);
        check("busy_out", dataOut, {32'd2, 32'd14});
        repeat (40) @(posedge clk);
        #1;
        check("busy_npulse", 64'(pulses - p0), 64'd1);

        // Reset mid-run aborts the division
        start(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        p0 = pulses;
        reset = 1'b0;
        #1;
        check("mid_out", dataOut, 64'd0);
        check("mid_flags", {61'd0, busy, done, divZero}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("mid_nodone", 64'(pulses - p0), 64'd0);
        check("mid_out2", dataOut, 64'd0);

        run_div("d9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
